imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Boot-time controller that fills Instruction_Memory from a byte stream (UART receiver or testbench driver) before the core runs.
- Holds the single-cycle core in reset while loading.
- Assembles little-endian 32-bit words and issues word-aligned writes through the instruction memory write port.
- Releases the core, with PC starting at BASE_ADDR, once the declared program length has been written.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at the rising edge.
- reload  input  1  single-cycle pulse; restarts the load from the DONE or ERR state.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  32  byte address of the write, always word aligned.
- imem_wdata  output  32  word to write.
- core_reset_n  output  1  active-low reset to the core; low while loading.
- done  output  1  load completed successfully.
- error  output  1  header word count exceeded DEPTH_WORDS.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low. Reset forces state HDR, byte_cnt=0, word_cnt=0, len=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset_n=0, done=0, error=0.
- Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, each little-endian (first byte goes to bits [7:0]).
- State HDR:
  - in_ready=1; each accepted byte is shifted into len at position byte_cnt.
  - On the 4th byte, byte_cnt wraps to 0, then:
    - N==0 -> DONE.
    - N>DEPTH_WORDS -> ERR.
    - otherwise -> DATA.
- State DATA:
  - in_ready=1; bytes are assembled into a word shift register.
  - On the handshake of the 4th byte of word k, the next cycle has imem_we=1, imem_addr=BASE_ADDR+4*k, imem_wdata=assembled word. This is exactly one cycle of latency and a single-cycle pulse.
  - in_ready stays high during the write cycle, so back-to-back bytes incur no stall; a write cycle may coincide with acceptance of the next word's first byte.
  - When k==N-1 the write is issued and the state moves to DONE.
- State DONE:
  - done=1 and core_reset_n=1, registered, asserted the cycle after the final imem_we pulse. For N==0 they are asserted the cycle after the 4th header byte.
  - in_ready=0; incoming bytes are ignored.
- State ERR:
  - error=1, core_reset_n=0, in_ready=0.
- reload:
  - Honoured only in DONE or ERR; ignored in HDR and DATA.
  - Next cycle: state HDR, counters cleared, done=0, error=0, core_reset_n=0.
- in_valid low mid-word: byte assembly holds; there is no timeout.
- Asynchronous reset mid-load: everything returns to reset values immediately; partial words are discarded; memory contents already written are untouched.
- Counters:
  - word_cnt is wide enough for DEPTH_WORDS ($clog2(DEPTH_WORDS)+1 bits).
  - The full 32-bit len is compared against DEPTH_WORDS; it is never truncated before the comparison.
  - imem_addr never exceeds BASE_ADDR+4*(DEPTH_WORDS-1).

Decomposition:
- Package imem_boot_pkg:
  - state enum {HDR, DATA, DONE, ERR}.
  - BYTES_PER_WORD=4.
- Sub-module byte_word_assembler: byte_cnt, the little-endian shift register, and a word_valid pulse. Shared by the header and data paths.
- The FSM, address counter and output registers live in the top module.

Test Plan:
- Reset then stream 02 00 00 00, 13 05 50 00, 93 05 A0 00 with in_valid always high -> imem_we pulses with addr 0x0/data 0x00500513 and addr 0x4/data 0x00A00593; done=1 and core_reset_n=1 the cycle after the second pulse.
- Header 00 00 00 00 -> no imem_we; done=1 the cycle after the 4th byte; in_ready=0 afterward.
- Header 41 00 00 00 (65 > 64) -> error=1, core_reset_n=0, no writes; then a reload pulse -> error=0 and in_ready=1 next cycle.
- Header 01 00 00 00 followed by the word 0x00000033 with in_valid toggling 1,0,0,1,0,1,1 -> a single write at addr 0x0 of 0x00000033, issued one cycle after the last byte handshake.
- Assert reset_n low after 2 data bytes of word 1 (N=3), then reload the full 3-word stream -> all outputs are at reset values during reset; the final writes are at 0x0, 0x4 and 0x8; no stale byte merges into a word.
- After DONE, in DONE state, drive reload together with in_valid and byte 0xFF -> the byte is not consumed; the next cycle is HDR with done=0 and core_reset_n=0.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package imem_boot_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs an accepted byte stream into little-endian 32-bit words; the word is
// presented combinationally on the handshake of its last byte.
module byte_word_assembler
  import imem_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned SHR_W = WORD_W - BYTE_W;

  logic [BCNT_W-1:0] byte_cnt;
  logic [SHR_W-1:0]  shreg;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + BCNT_W'(1);
      shreg    <= {byte_data, shreg[SHR_W-1:BYTE_W]};
    end
  end

  assign word_valid_c = byte_valid && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
  assign word_c       = {byte_data, shreg};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: reads a length header and N little-endian words from a byte
// stream, writes them to instruction memory, then releases the core.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset_n,
  output logic        done,
  output logic        error
);

  localparam int unsigned WCNT_W = $clog2(DEPTH_WORDS) + 1;

  state_e            state, next_state;
  logic [WCNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [WORD_W-1:0] len, len_nxt;
  imem_wr_t          wr_nxt;
  logic              imem_we_nxt, done_nxt, error_nxt, core_reset_n_nxt, in_ready_nxt;
  logic              byte_valid, word_valid_c, last_word_c, reload_ok_c;
  logic [WORD_W-1:0] word_c;

  assign byte_valid  = in_valid && in_ready;
  assign reload_ok_c = reload && ((state == DONE) || (state == ERR));
  assign last_word_c = (WORD_W'(word_cnt) + WORD_W'(1)) == len;

  byte_word_assembler u_asm (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr          (reload_ok_c),
    .byte_valid   (byte_valid),
    .byte_data    (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HDR;
      word_cnt     <= '0;
      len          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      state        <= next_state;
      word_cnt     <= word_cnt_nxt;
      len          <= len_nxt;
      imem_we      <= imem_we_nxt;
      imem_addr    <= wr_nxt.addr;
      imem_wdata   <= wr_nxt.data;
      core_reset_n <= core_reset_n_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
      in_ready     <= in_ready_nxt;
    end
  end

  // Next-state: the full 32-bit header is range checked.
  always_comb begin
    next_state = state;
    case (state)
      HDR: begin
        if (word_valid_c) begin
          if (word_c == '0)                           next_state = DONE;
          else if (word_c > WORD_W'(DEPTH_WORDS))     next_state = ERR;
          else                                        next_state = DATA;
        end
      end
      DATA:      if (word_valid_c && last_word_c) next_state = DONE;
      DONE, ERR: if (reload)                      next_state = HDR;
      default:   next_state = HDR;
    endcase
  end

  // Outputs and counters; done trails the final write pulse by one cycle.
  always_comb begin
    word_cnt_nxt     = word_cnt;
    len_nxt          = len;
    imem_we_nxt      = 1'b0;
    wr_nxt.addr      = imem_addr;
    wr_nxt.data      = imem_wdata;
    if ((state == HDR) && word_valid_c) begin
      len_nxt      = word_c;
      word_cnt_nxt = '0;
    end
    if ((state == DATA) && word_valid_c) begin
      imem_we_nxt  = 1'b1;
      wr_nxt.addr  = BASE_ADDR + (WORD_W'(word_cnt) << 2);
      wr_nxt.data  = word_c;
      word_cnt_nxt = word_cnt + WCNT_W'(1);
    end
    if (reload_ok_c) begin
      word_cnt_nxt = '0;
      len_nxt      = '0;
    end
    done_nxt         = (next_state == DONE) && (state != DATA);
    core_reset_n_nxt = done_nxt;
    error_nxt        = (next_state == ERR);
    in_ready_nxt     = (next_state == HDR) || (next_state == DATA);
  end

endmodule
